// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter with a small input FIFO.
//
// Bytes enter over a valid/ready handshake, wait in a FIFO_DEPTH-entry FIFO
// and are sent one after another as 8N1 frames: a start bit, eight data bits
// LSB first, then one stop bit. Each bit lasts SYS_CLOCK / UART_BAUDRATE
// clock cycles, which is the same bit timing the uart_rx block uses.
//
// Ports:
//   i_SysClock  in   system clock, rising edge
//   i_Reset     in   asynchronous, active-high reset
//   i_TxValid   in   i_TxByte holds a byte to enqueue
//   i_TxByte    in   [7:0] byte to transmit
//   o_TxReady   out  FIFO can accept a byte this cycle (not full)
//   o_TxSerial  out  serial line, idles high, registered
//   o_TxBusy    out  frame in progress or FIFO non-empty
//   o_TxDone    out  one-cycle pulse on the last cycle of each stop bit
//
// Handshake: a byte is taken on every rising edge where i_TxValid and
// o_TxReady are both high. o_TxReady depends only on the FIFO occupancy, so
// it never waits on i_TxValid, and it ignores a pop happening in the same
// cycle. The producer may change i_TxByte freely once the byte is taken.
module uart_tx #(
    parameter int SYS_CLOCK     = 50000000,
    parameter int UART_BAUDRATE = 115200,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       i_SysClock,
    input  logic       i_Reset,
    input  logic       i_TxValid,
    input  logic [7:0] i_TxByte,
    output logic       o_TxReady,
    output logic       o_TxSerial,
    output logic       o_TxBusy,
    output logic       o_TxDone
);

    localparam int BIT_CYCLES = SYS_CLOCK / UART_BAUDRATE;
    localparam int TMR_W      = $clog2(BIT_CYCLES);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BIT_CYCLES - 1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t           state_q,  state_d;
    logic [TMR_W-1:0] timer_q,  timer_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,  shift_d;
    logic             serial_q, serial_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    logic [7:0] fifo_mem [FIFO_DEPTH];

    logic push;
    logic pop;
    logic bit_end;

    assign push    = i_TxValid && (count_q != CNT_FULL);
    assign bit_end = (timer_q == TMR_LAST);

    // Next-state logic. The timer clears whenever a new bit period starts
    // (state entry, or the next data bit inside S_DATA).
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem[rd_ptr_q];
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    timer_d   = '0;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    timer_d = '0;
                    // Chain straight into the next start bit so frames abut.
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = fifo_mem[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                timer_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // The line level is derived from the next state so the registered
    // output changes on the same edge as the state itself.
    always_comb begin
        serial_d = 1'b1;
        case (state_d)
            S_IDLE:  serial_d = 1'b1;
            S_START: serial_d = 1'b0;
            S_DATA:  serial_d = shift_d[0];
            S_STOP:  serial_d = 1'b1;
            default: serial_d = 1'b1;
        endcase
    end

    // FIFO bookkeeping; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_SysClock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            serial_q  <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge i_SysClock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= i_TxByte;
        end
    end

    assign o_TxReady  = (count_q != CNT_FULL);
    assign o_TxSerial = serial_q;
    assign o_TxBusy   = (state_q != S_IDLE) || (count_q != '0);
    assign o_TxDone   = (state_q == S_STOP) && bit_end;

endmodule
